// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mult_sign_conv.sv
// Converts one operand to an unsigned magnitude plus sign bit.
// The magnitude is one bit wider so the most negative operand converts cleanly.
module mult_sign_conv
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_operand,
  input  logic             i_signed_mode,
  output logic [WIDTH:0]   o_mag,
  output logic             o_sign
);

  logic signed [WIDTH:0] w_ext;

  always_comb begin
    o_sign = (i_signed_mode == MODE_SIGNED) && i_operand[WIDTH-1];
    w_ext  = {o_sign, i_operand};
    o_mag  = o_sign ? $unsigned(-w_ext) : $unsigned(w_ext);
  end

endmodule

// File: rtl/seq_mult_hs.sv
// Sequential shift-add multiplier with valid/ready handshakes on both sides.
// One operation at a time: IDLE accepts, CALC runs WIDTH steps, DONE holds the product.
module seq_mult_hs
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic                       signed_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [prod_w(WIDTH)-1:0]   product,
  output logic                       busy
);

  localparam int PW = prod_w(WIDTH);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          r_state;
  state_t          w_next;
  logic [WIDTH:0]  r_mcand;
  logic [WIDTH:0]  r_mplier;
  logic            r_sign;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_product;
  logic [CW-1:0]   r_count;

  logic [WIDTH:0]  w_mag_a;
  logic [WIDTH:0]  w_mag_b;
  logic            w_sign_a;
  logic            w_sign_b;
  logic [PW-1:0]   w_addend;
  logic [PW-1:0]   w_acc_next;
  logic            w_last;
  logic            w_accept;

  mult_sign_conv #(.WIDTH(WIDTH)) u_conv_a (
    .i_operand     (a),
    .i_signed_mode (signed_mode),
    .o_mag         (w_mag_a),
    .o_sign        (w_sign_a)
  );

  mult_sign_conv #(.WIDTH(WIDTH)) u_conv_b (
    .i_operand     (b),
    .i_signed_mode (signed_mode),
    .o_mag         (w_mag_b),
    .o_sign        (w_sign_b)
  );

  always_comb begin
    w_addend   = PW'(r_mcand) << r_count;
    w_acc_next = r_acc + (r_mplier[0] ? w_addend : '0);
    w_last     = (r_count == LAST);
    w_accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CALC;
      CALC:    if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_sign    <= 1'b0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_sign   <= w_sign_a ^ w_sign_b;
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        CALC: begin
          r_acc    <= w_acc_next;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
          // Negating a zero magnitude yields zero, so no negative zero escapes.
          if (w_last) r_product <= r_sign ? (~w_acc_next + 1'b1) : w_acc_next;
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;

endmodule
